// File: rtl/obi_mem_sbr.sv
// OBI subordinate backed by a word-addressed RAM, with in-order responses
// queued in a small FIFO so up to MAX_OUT requests can be outstanding.
module obi_mem_sbr #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                AID_W     = 1,
  parameter int                N_WORDS   = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 'h1000_0000,
  parameter int                MAX_OUT   = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_i,
  output logic                gnt_o,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic                we_i,
  input  logic [DATA_W/8-1:0] be_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [AID_W-1:0]    aid_i,
  input  logic [5:0]          atop_i,
  output logic                rvalid_o,
  input  logic                rready_i,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                err_o,
  output logic [AID_W-1:0]    rid_o
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = $clog2(N_WORDS);
  localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam logic [ADDR_W:0]  SPAN     = (ADDR_W + 1)'(N_WORDS) << 2;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUT);

  logic [DATA_W-1:0] mem [N_WORDS];

  logic [DATA_W-1:0] fifo_rdata [MAX_OUT];
  logic              fifo_err   [MAX_OUT];
  logic [AID_W-1:0]  fifo_rid   [MAX_OUT];

  logic [PTR_W-1:0]  wptr, rptr;
  logic [CNT_W-1:0]  cnt;

  logic [ADDR_W-1:0] offset;
  logic [IDX_W-1:0]  word_idx;
  logic              in_range, req_err, accept, retire;
  logic [DATA_W-1:0] push_rdata;

  // Offset wraps for addresses below BASE_ADDR, so a single compare covers both ends.
  assign offset     = addr_i - BASE_ADDR;
  assign in_range   = {1'b0, offset} < SPAN;
  assign req_err    = !in_range || (atop_i != 6'd0);
  assign word_idx   = offset[2 +: IDX_W];

  assign gnt_o      = req_i && rst_ni && (cnt < CNT_MAX);
  assign accept     = req_i && gnt_o;
  assign rvalid_o   = (cnt != '0);
  assign retire     = rvalid_o && rready_i;

  assign push_rdata = (req_err || we_i) ? '0 : mem[word_idx];

  assign rdata_o    = rvalid_o ? fifo_rdata[rptr] : '0;
  assign err_o      = rvalid_o ? fifo_err[rptr]   : 1'b0;
  assign rid_o      = rvalid_o ? fifo_rid[rptr]   : '0;

  // Storage and FIFO payload carry no reset; contents survive rst_ni.
  always_ff @(posedge clk_i) begin
    if (accept && !req_err && we_i) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be_i[b]) mem[word_idx][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    if (accept) begin
      fifo_rdata[wptr] <= push_rdata;
      fifo_err[wptr]   <= req_err;
      fifo_rid[wptr]   <= aid_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (accept) wptr <= (wptr == PTR_LAST) ? '0 : wptr + 1'b1;
      if (retire) rptr <= (rptr == PTR_LAST) ? '0 : rptr + 1'b1;
      case ({accept, retire})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_obi_mem_sbr.sv
// Self-checking bench for obi_mem_sbr: a reference model pushes expected
// responses on every grant and a monitor pops and compares them on retire.
module tb_obi_mem_sbr;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        aid;
  logic [5:0]  atop;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic        err;
  logic        rid;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        rid;
  } resp_t;

  resp_t       scoreboard[$];
  logic [31:0] modelMem [int];
  logic [31:0] lastRdata;
  int          total = 0;
  int          bad   = 0;

  obi_mem_sbr dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .req_i    (req),
    .gnt_o    (gnt),
    .addr_i   (addr),
    .we_i     (we),
    .be_i     (be),
    .wdata_i  (wdata),
    .aid_i    (aid),
    .atop_i   (atop),
    .rvalid_o (rvalid),
    .rready_i (rready),
    .rdata_o  (rdata),
    .err_o    (err),
    .rid_o    (rid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Reference behaviour of one accepted request; writes land before the next cycle's read.
  task automatic modelAccept();
    logic [31:0] off;
    int          idx;
    resp_t       r;
    off = addr - 32'h1000_0000;
    idx = int'(off[11:2]);
    r.rid = aid;
    r.rdata = '0;
    r.err = (off >= 32'd4096) || (atop != 6'd0);
    if (!r.err) begin
      if (!modelMem.exists(idx)) modelMem[idx] = '0;
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) modelMem[idx][8*b +: 8] = wdata[8*b +: 8];
      end else begin
        r.rdata = modelMem[idx];
      end
    end
    scoreboard.push_back(r);
  endtask

  // Outputs are sampled on the falling edge, half a cycle clear of the active edge.
  always @(negedge clk) begin
    resp_t exp;
    logic  expGnt;
    if (!rst_n) begin
      scoreboard.delete();
      checkOutput("rst_rvalid", {31'd0, rvalid}, 32'd0);
      checkOutput("rst_gnt",    {31'd0, gnt},    32'd0);
      checkOutput("rst_rdata",  rdata,           32'd0);
      checkOutput("rst_err",    {31'd0, err},    32'd0);
      checkOutput("rst_rid",    {31'd0, rid},    32'd0);
    end else begin
      expGnt = req && (scoreboard.size() < 2);
      checkOutput("gnt",    {31'd0, gnt},    {31'd0, expGnt});
      checkOutput("rvalid", {31'd0, rvalid}, {31'd0, scoreboard.size() != 0});
      if (rvalid && rready && scoreboard.size() != 0) begin
        exp = scoreboard.pop_front();
        checkOutput("rdata", rdata,           exp.rdata);
        checkOutput("err",   {31'd0, err},    {31'd0, exp.err});
        checkOutput("rid",   {31'd0, rid},    {31'd0, exp.rid});
        lastRdata = rdata;
      end
      if (req && gnt) modelAccept();
    end
  end

  // One clock of stimulus; inputs change 1 time unit after the rising edge.
  task automatic applyStimulus(input logic r, input logic w, input logic [31:0] a, input logic [3:0] b,
                               input logic [31:0] d, input logic i, input logic [5:0] at,
                               input logic rr, output logic granted);
    req = r; we = w; addr = a; be = b; wdata = d; aid = i; atop = at; rready = rr;
    @(negedge clk);
    granted = gnt;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic g;
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 6'h0, 1'b1, g);
  endtask

  task automatic doTxn(input logic w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] d, input logic i, input logic [5:0] at);
    logic g;
    int   tries;
    g = 1'b0;
    tries = 0;
    while (!g && tries < 20) begin
      applyStimulus(1'b1, w, a, b, d, i, at, 1'b1, g);
      tries++;
    end
    if (!g) checkOutput("grant_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (scoreboard.size() != 0 && n < 30) begin
      idle(1);
      n++;
    end
    idle(1);
    checkOutput("drain", scoreboard.size(), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic g;
    int   grants;
    rst_n = 1'b0;
    req = 0; we = 0; addr = 0; be = 0; wdata = 0; aid = 0; atop = 0; rready = 0;

    // Requests during reset must not be granted.
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, 32'h1000_0010, 4'hF, 32'h0, 1'b0, 6'h0, 1'b1, g);
    rst_n = 1'b1;
    idle(1);

    doTxn(1'b1, 32'h1000_0014, 4'hF, 32'h0101_0101, 1'b0, 6'h0);
    doTxn(1'b1, 32'h1000_0018, 4'hF, 32'h0202_0202, 1'b1, 6'h0);
    doTxn(1'b1, 32'h1000_001C, 4'hF, 32'h0303_0303, 1'b0, 6'h0);
    drain();

    doTxn(1'b1, 32'h1000_0010, 4'hF, 32'hDEAD_BEEF, 1'b1, 6'h0);
    doTxn(1'b0, 32'h1000_0010, 4'h0, 32'h0,         1'b0, 6'h0);
    drain();
    checkOutput("read_after_write", lastRdata, 32'hDEAD_BEEF);

    doTxn(1'b1, 32'h1000_0010, 4'b0101, 32'h1122_3344, 1'b0, 6'h0);
    doTxn(1'b0, 32'h1000_0010, 4'h0,    32'h0,         1'b1, 6'h0);
    drain();
    checkOutput("byte_merge", lastRdata, 32'hDE22_BE44);

    doTxn(1'b0, 32'h1000_1000, 4'hF, 32'h0,         1'b1, 6'h0);
    doTxn(1'b0, 32'h0FFF_FFFC, 4'hF, 32'h0,         1'b0, 6'h0);
    doTxn(1'b0, 32'h1000_0010, 4'hF, 32'h0,         1'b1, 6'h20);
    doTxn(1'b1, 32'h1000_0010, 4'hF, 32'h5555_AAAA, 1'b0, 6'h20);
    doTxn(1'b1, 32'h1000_1000, 4'hF, 32'h7777_7777, 1'b1, 6'h0);
    doTxn(1'b0, 32'h1000_0010, 4'h0, 32'h0,         1'b1, 6'h0);
    drain();
    checkOutput("err_no_side_effect", lastRdata, 32'hDE22_BE44);

    doTxn(1'b1, 32'h1000_0FFF, 4'hF, 32'hCAFE_F00D, 1'b0, 6'h0);
    doTxn(1'b0, 32'h1000_0FFC, 4'h0, 32'h0,         1'b1, 6'h0);
    drain();
    checkOutput("last_word", lastRdata, 32'hCAFE_F00D);

    // Outstanding limit: with responses blocked only two requests are accepted.
    grants = 0;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, 1'b0, 32'h1000_0014 + 32'(4 * (k % 3)), 4'h0, 32'h0, k[0], 6'h0, 1'b0, g);
      grants += int'(g);
    end
    checkOutput("stall_grants", grants, 32'd2);
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b0, 32'h1000_001C, 4'h0, 32'h0, 1'b1, 6'h0, 1'b1, g);
    drain();

    grants = 0;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 1'b0, 32'h1000_0010 + 32'(4 * (k % 4)), 4'h0, 32'h0,
                    1'($urandom_range(0, 1)), 6'h0, 1'b1, g);
      grants += int'(g);
    end
    checkOutput("burst_grants", grants, 32'd8);
    drain();

    // Reset with two responses pending; storage must survive.
    doTxn(1'b1, 32'h1000_0018, 4'hF, 32'hA5A5_5A5A, 1'b0, 6'h0);
    drain();
    for (int k = 0; k < 2; k++) applyStimulus(1'b1, 1'b0, 32'h1000_0018, 4'h0, 32'h0, k[0], 6'h0, 1'b0, g);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_rvalid", {31'd0, rvalid}, 32'd0);
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) applyStimulus(1'b1, 1'b0, 32'h1000_0018, 4'h0, 32'h0, 1'b0, 6'h0, 1'b1, g);
    rst_n = 1'b1;
    idle(1);
    doTxn(1'b0, 32'h1000_0018, 4'h0, 32'h0, 1'b1, 6'h0);
    drain();
    checkOutput("retain_after_rst", lastRdata, 32'hA5A5_5A5A);

    // Mixed traffic over the initialised words with random backpressure.
    for (int k = 0; k < 60; k++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    32'h1000_0010 + 32'(4 * $urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                    $urandom, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) == 0) ? 6'h01 : 6'h00,
                    ($urandom_range(0, 3) != 0), g);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
